commit_free_list: RTL and testbench

- Physical-register free list plus retirement (commit) RAT. It sits directly downstream of the ROB commit port and upstream of rename.
- On each ROB commit it looks up the previous committed mapping of arch_rd and returns that physical register to the free list, then records the new mapping.
- Rename draws new physical destination registers from the same list, up to DISPATCH_WIDTH per cycle.

---
 rtl/commit_free_list.sv | 94 +++++++++
 tb/tb_commit_free_list.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_free_list.sv
// Physical-register free list with retirement RAT: commits return the previous mapping
// of arch_rd to the list, rename allocates up to DISPATCH_WIDTH tags per cycle.
module commit_free_list #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int PHYS_REG_NUM   = 64,
  parameter int ARCH_REG_NUM   = 32,
  parameter int FREE_DEPTH     = PHYS_REG_NUM - ARCH_REG_NUM
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DISPATCH_WIDTH-1:0]      alloc_req,
  output logic                           alloc_ok,
  output logic [DISPATCH_WIDTH-1:0][7:0] alloc_phys,
  input  logic [DISPATCH_WIDTH-1:0]      commit_en,
  input  logic [DISPATCH_WIDTH-1:0][7:0] commit_phys_rd,
  input  logic [DISPATCH_WIDTH-1:0][4:0] commit_arch_rd,
  output logic [5:0]                     free_count,
  output logic                           overflow_err
);
  localparam int PTR_W = $clog2(FREE_DEPTH);
  localparam int CNT_W = 7;
  localparam int IDX_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  // Handshake: alloc_req is the request, alloc_ok the all-or-nothing grant; a transfer
  // happens on a posedge where alloc_ok is high. With alloc_ok low nothing is consumed
  // and rename holds alloc_req until granted. alloc_phys[w] is meaningful only when
  // alloc_req[w] && alloc_ok.

  logic [7:0]       free_list [FREE_DEPTH];
  logic [7:0]       rat       [ARCH_REG_NUM];
  logic [7:0]       rat_next  [ARCH_REG_NUM];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] n_req;
  logic [CNT_W-1:0] n_free;
  logic [CNT_W-1:0] n_keep;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] room;
  logic             free_overflow;
  logic [DISPATCH_WIDTH-1:0][7:0] free_tag;

  // Running request count doubles as the packing offset for each lane.
  always_comb begin
    n_req      = '0;
    alloc_phys = '0;
    for (int w = 0; w < DISPATCH_WIDTH; w++) begin
      alloc_phys[w] = free_list[head + PTR_W'(n_req)];
      if (alloc_req[w]) n_req = n_req + CNT_W'(1);
    end
    alloc_ok = ({1'b0, free_count} >= n_req);
  end

  // Lanes resolve in order, so a later lane sees an earlier lane's RAT update.
  always_comb begin
    rat_next = rat;
    n_free   = '0;
    free_tag = '0;
    for (int w = 0; w < DISPATCH_WIDTH; w++) begin
      if (commit_en[w] && (commit_arch_rd[w] != 5'd0)) begin
        free_tag[n_free[IDX_W-1:0]] = rat_next[commit_arch_rd[w]];
        rat_next[commit_arch_rd[w]] = commit_phys_rd[w];
        n_free = n_free + CNT_W'(1);
      end
    end
  end

  // Frees that would push the count past capacity are dropped, highest lanes first.
  always_comb begin
    base          = {1'b0, free_count} - (alloc_ok ? n_req : CNT_W'(0));
    room          = CNT_W'(FREE_DEPTH) - base;
    free_overflow = (n_free > room);
    n_keep        = free_overflow ? room : n_free;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REG_NUM; i++) rat[i] <= 8'(i);
      for (int k = 0; k < FREE_DEPTH; k++) free_list[k] <= 8'(ARCH_REG_NUM + k);
      head         <= '0;
      tail         <= '0;
      free_count   <= 6'(FREE_DEPTH);
      overflow_err <= 1'b0;
    end else begin
      if (alloc_ok) head <= head + PTR_W'(n_req);
      for (int w = 0; w < DISPATCH_WIDTH; w++) begin
        if (CNT_W'(w) < n_keep) free_list[tail + PTR_W'(w)] <= free_tag[w];
      end
      tail       <= tail + PTR_W'(n_keep);
      rat        <= rat_next;
      free_count <= 6'(base + n_keep);
      if (free_overflow) overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_commit_free_list.sv
// Directed bench for commit_free_list: allocation packing, stall, commit/free ordering,
// overflow clamping, pointer wrap under steady traffic and mid-stream reset.
module tb_commit_free_list;
  logic             clk;
  logic             rst;
  logic [1:0]       alloc_req;
  logic             alloc_ok;
  logic [1:0][7:0]  alloc_phys;
  logic [1:0]       commit_en;
  logic [1:0][7:0]  commit_phys_rd;
  logic [1:0][4:0]  commit_arch_rd;
  logic [5:0]       free_count;
  logic             overflow_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rat_m [32];
  logic [63:0] owned;

  commit_free_list #(.DISPATCH_WIDTH(2), .PHYS_REG_NUM(64), .ARCH_REG_NUM(32)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_phys(alloc_phys), .commit_en(commit_en), .commit_phys_rd(commit_phys_rd),
    .commit_arch_rd(commit_arch_rd), .free_count(free_count), .overflow_err(overflow_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_req      = 2'b00;
    commit_en      = 2'b00;
    commit_phys_rd = '0;
    commit_arch_rd = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
  endtask

  task automatic commit2(input logic [1:0] en, input logic [4:0] a0, input logic [7:0] p0,
                         input logic [4:0] a1, input logic [7:0] p1);
    commit_en         = en;
    commit_arch_rd[0] = a0;
    commit_phys_rd[0] = p0;
    commit_arch_rd[1] = a1;
    commit_phys_rd[1] = p1;
  endtask

  task automatic model_commit(input logic [4:0] a, input logic [7:0] p);
    logic [7:0] old;
    old = rat_m[a];
    exp_q.push_back(old);
    owned[old[5:0]] = 1'b0;
    rat_m[a] = p;
    owned[p[5:0]] = 1'b1;
  endtask

  initial begin
    logic [7:0] e0, e1;
    logic [4:0] a0, a1;
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;

    // reset state
    chk("reset_free_count", 32'(free_count), 32);
    chk("reset_overflow", 32'(overflow_err), 0);
    #1 chk("reset_ok_no_req", 32'(alloc_ok), 1);

    // dual alloc right after reset
    alloc_req = 2'b11;
    #1;
    chk("dual_ok", 32'(alloc_ok), 1);
    chk("dual_lane0", 32'(alloc_phys[0]), 32);
    chk("dual_lane1", 32'(alloc_phys[1]), 33);
    tick();
    alloc_req = 2'b00;
    chk("dual_count", 32'(free_count), 30);

    // lane1-only request packs into slot 0
    do_reset();
    alloc_req = 2'b10;
    #1 chk("lane1_only", 32'(alloc_phys[1]), 32);
    tick();
    chk("lane1_count", 32'(free_count), 31);
    alloc_req = 2'b11;
    #1;
    chk("next_lane0", 32'(alloc_phys[0]), 33);
    chk("next_lane1", 32'(alloc_phys[1]), 34);
    tick();
    chk("next_count", 32'(free_count), 29);

    // drain to one entry, then stall and single grant
    for (int i = 0; i < 14; i++) begin
      #1;
      chk("drain_lane0", 32'(alloc_phys[0]), 32'(35 + 2 * i));
      chk("drain_lane1", 32'(alloc_phys[1]), 32'(36 + 2 * i));
      tick();
    end
    chk("drain_count", 32'(free_count), 1);
    #1 chk("stall_ok", 32'(alloc_ok), 0);
    tick();
    chk("stall_count", 32'(free_count), 1);
    alloc_req = 2'b01;
    #1;
    chk("last_ok", 32'(alloc_ok), 1);
    chk("last_phys", 32'(alloc_phys[0]), 63);
    tick();
    chk("empty_count", 32'(free_count), 0);
    #1 chk("empty_stall", 32'(alloc_ok), 0);
    alloc_req = 2'b00;
    #1 chk("empty_no_req_ok", 32'(alloc_ok), 1);

    // commit frees previous mapping, in lane order
    do_reset();
    alloc_req = 2'b11;
    tick();
    tick();
    alloc_req = 2'b00;
    chk("pre_commit_count", 32'(free_count), 28);
    commit2(2'b01, 5'd5, 8'd40, 5'd0, 8'd0);
    tick();
    chk("commit5_count", 32'(free_count), 29);
    commit2(2'b11, 5'd3, 8'd50, 5'd3, 8'd51);
    tick();
    chk("same_arch_count", 32'(free_count), 31);
    commit2(2'b11, 5'd0, 8'd60, 5'd0, 8'd61);
    tick();
    chk("arch0_ignored", 32'(free_count), 31);
    idle_inputs();
    alloc_req = 2'b11;
    for (int i = 0; i < 14; i++) begin
      #1;
      chk("wrap_lane0", 32'(alloc_phys[0]), 32'(36 + 2 * i));
      chk("wrap_lane1", 32'(alloc_phys[1]), 32'(37 + 2 * i));
      tick();
    end
    #1;
    chk("freed_5", 32'(alloc_phys[0]), 5);
    chk("freed_3", 32'(alloc_phys[1]), 3);
    tick();
    alloc_req = 2'b01;
    #1 chk("freed_50", 32'(alloc_phys[0]), 50);
    tick();
    alloc_req = 2'b00;
    chk("reuse_count", 32'(free_count), 0);
    commit2(2'b11, 5'd5, 8'd7, 5'd3, 8'd8);
    tick();
    idle_inputs();
    chk("rat_free_count", 32'(free_count), 2);
    alloc_req = 2'b11;
    #1;
    chk("rat5_was_40", 32'(alloc_phys[0]), 40);
    chk("rat3_was_51", 32'(alloc_phys[1]), 51);
    tick();
    alloc_req = 2'b00;
    chk("rat_drain_count", 32'(free_count), 0);

    // overflow from full list, sticky until reset
    do_reset();
    commit2(2'b01, 5'd5, 8'd40, 5'd0, 8'd0);
    tick();
    idle_inputs();
    chk("ovf_clamp", 32'(free_count), 32);
    chk("ovf_set", 32'(overflow_err), 1);
    tick();
    chk("ovf_sticky", 32'(overflow_err), 1);
    do_reset();
    chk("ovf_reset", 32'(overflow_err), 0);

    // partial overflow keeps lane0 free and drops lane1
    alloc_req = 2'b01;
    tick();
    alloc_req = 2'b00;
    commit2(2'b11, 5'd6, 8'd32, 5'd7, 8'd9);
    tick();
    idle_inputs();
    chk("part_ovf_count", 32'(free_count), 32);
    chk("part_ovf_flag", 32'(overflow_err), 1);
    alloc_req = 2'b11;
    for (int i = 0; i < 15; i++) tick();
    #1;
    chk("part_tail_lane0", 32'(alloc_phys[0]), 63);
    chk("part_kept_lane0_free", 32'(alloc_phys[1]), 6);
    tick();
    alloc_req = 2'b00;
    chk("part_drain_count", 32'(free_count), 0);

    // steady 2 alloc + 2 commit, wrapping pointers several times
    do_reset();
    exp_q.delete();
    for (int k = 32; k < 64; k++) exp_q.push_back(8'(k));
    owned = '0;
    for (int i = 0; i < 32; i++) begin
      rat_m[i] = 8'(i);
      owned[i] = 1'b1;
    end
    for (int t = 0; t < 40; t++) begin
      alloc_req = 2'b11;
      #1;
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      chk("stress_ok", 32'(alloc_ok), 1);
      chk("stress_lane0", 32'(alloc_phys[0]), 32'(e0));
      chk("stress_lane1", 32'(alloc_phys[1]), 32'(e1));
      chk("stress_dup0", 32'(owned[alloc_phys[0][5:0]]), 0);
      chk("stress_dup1", 32'(owned[alloc_phys[1][5:0]]), 0);
      a0 = 5'(1 + (t % 31));
      a1 = 5'(1 + ((t * 7) % 31));
      commit2(2'b11, a0, e0, a1, e1);
      model_commit(a0, e0);
      model_commit(a1, e1);
      tick();
      chk("stress_count", 32'(free_count), 32);
    end
    chk("stress_ovf", 32'(overflow_err), 0);

    // reset asserted with traffic in flight
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle_inputs();
    chk("midrst_count", 32'(free_count), 32);
    chk("midrst_ovf", 32'(overflow_err), 0);
    alloc_req = 2'b11;
    #1;
    chk("midrst_lane0", 32'(alloc_phys[0]), 32);
    chk("midrst_lane1", 32'(alloc_phys[1]), 33);
    tick();
    alloc_req = 2'b00;
    commit2(2'b11, 5'd1, 8'd32, 5'd2, 8'd33);
    tick();
    idle_inputs();
    chk("midrst_free_count", 32'(free_count), 32);
    alloc_req = 2'b11;
    for (int i = 0; i < 15; i++) tick();
    #1;
    chk("midrst_rat1", 32'(alloc_phys[0]), 1);
    chk("midrst_rat2", 32'(alloc_phys[1]), 2);
    tick();
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
